// File: rtl/time_set_control.sv
// time_set_control: front-panel buttons/switches to a clamped BCD time preset, patient ID and run lock.
// Optional TIME_SET_CONTROL_DEBOUNCE_EN adds a per-button counter filter ahead of edge detection.
module time_set_control #(
  parameter int NUM_DIGITS      = 6,
  parameter int ID_W            = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    btn_clear,
  input  logic                    btn_set,
  input  logic                    btn_load,
  input  logic                    btn_start,
  input  logic                    btn_stop,
  input  logic                    mode_24h,
  input  logic [3:0]              digit_sw,
  input  logic [ID_W-1:0]         id_sw,
  output logic [4*NUM_DIGITS-1:0] time_digits,
  output logic [ID_W-1:0]         patient_id,
  output logic [2:0]              state,
  output logic [2:0]              set_cursor,
  output logic                    set_done,
  output logic                    load_valid
);
  typedef enum logic [2:0] {
    CLEARED = 3'd0, SET = 3'd1, LOAD = 3'd2, RUN = 3'd3, IDLE = 3'd4, STOPPED = 3'd5
  } state_t;
  state_t st_q, st_d;
  logic [NUM_DIGITS-1:0][3:0] dig_q, dig_d;
  logic [ID_W-1:0] pid_q, pid_d;
  logic [2:0] cur_q, cur_d, idx;
  logic lock_q, lock_d, done_q, done_d, lv_q, lv_d;
  logic [4:0] raw, lvl, prev_q, ev;
  logic [3:0] tens, lim, val, hu_new;
  function automatic logic [3:0] hu_lim(input logic [3:0] t, input logic m);
    return m ? (t == 4'd2 ? 4'd3 : 4'd9) : (t == 4'd1 ? 4'd2 : 4'd9);
  endfunction
  assign raw = {btn_stop, btn_start, btn_load, btn_set, btn_clear};
`ifdef TIME_SET_CONTROL_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [4:0][CW-1:0] cnt_q, cnt_d;
  logic [4:0] flt_q, flt_d;
  // Counter runs only while raw disagrees with the filtered level; any agreement restarts it.
  always_comb begin
    cnt_d = '0;
    flt_d = flt_q;
    for (int i = 0; i < 5; i++)
      if (raw[i] != flt_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) flt_d[i] = raw[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt_q <= '0;
      flt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      flt_q <= flt_d;
    end
  assign lvl = flt_q;
`else
  assign lvl = raw;
`endif
  assign ev = lvl & ~prev_q;
  always_comb begin
    dig_d  = dig_q;
    pid_d  = pid_q;
    st_d   = st_q;
    cur_d  = cur_q;
    lock_d = lock_q;
    done_d = 1'b0;
    lv_d   = 1'b0;
    tens   = dig_q[NUM_DIGITS-1];
    idx    = 3'(NUM_DIGITS - 1) - cur_q;
    lim    = cur_q == 3'd0 ? (mode_24h ? 4'd2 : 4'd1) :
             cur_q == 3'd1 ? hu_lim(tens, mode_24h) : (cur_q[0] ? 4'd9 : 4'd5);
    val    = digit_sw > lim ? lim : digit_sw;
    hu_new = hu_lim(val, mode_24h);
    if (ev[0]) begin
      dig_d  = '0;
      cur_d  = '0;
      lock_d = 1'b0;
      st_d   = CLEARED;
    end else if (ev[1]) begin
      if (!lock_q) begin
        dig_d[idx] = val;
        // A new hour tens can shrink the limit of an already written hour units.
        if (cur_q == 3'd0 && dig_q[NUM_DIGITS-2] > hu_new) dig_d[NUM_DIGITS-2] = hu_new;
        st_d   = SET;
        done_d = cur_q == 3'(NUM_DIGITS - 1);
        cur_d  = done_d ? 3'd0 : cur_q + 3'd1;
      end
    end else if (ev[2]) begin
      if (!lock_q) begin
        pid_d = id_sw;
        lv_d  = 1'b1;
        st_d  = LOAD;
      end
    end else if (ev[3]) begin
      if (!lock_q) begin
        lock_d = 1'b1;
        st_d   = RUN;
      end
    end else if (ev[4]) begin
      if (st_q == RUN) begin
        lock_d = 1'b0;
        st_d   = STOPPED;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      dig_q  <= '0;
      pid_q  <= '0;
      st_q   <= IDLE;
      cur_q  <= '0;
      lock_q <= 1'b0;
      done_q <= 1'b0;
      lv_q   <= 1'b0;
      prev_q <= '0;
    end else begin
      dig_q  <= dig_d;
      pid_q  <= pid_d;
      st_q   <= st_d;
      cur_q  <= cur_d;
      lock_q <= lock_d;
      done_q <= done_d;
      lv_q   <= lv_d;
      prev_q <= lvl;
    end
  assign time_digits = dig_q;
  assign patient_id  = pid_q;
  assign state       = st_q;
  assign set_cursor  = cur_q;
  assign set_done    = done_q;
  assign load_valid  = lv_q;
endmodule

// File: tb/tb_time_set_control.sv
// tb_time_set_control: scoreboard bench for time_set_control (6-digit main instance, 4-digit side instance).
module tb_time_set_control;
  localparam logic [4:0] CLR = 5'b00001, SETB = 5'b00010, LD = 5'b00100, STA = 5'b01000, STP = 5'b10000;
  logic clk = 1'b0, reset_n = 1'b0, mode_24h = 1'b0;
  logic [4:0] btn = '0;
  logic [3:0] digit_sw = '0;
  logic [7:0] id_sw = '0;
  logic [23:0] td6;
  logic [15:0] td4;
  logic [7:0] pid6, pid4;
  logic [2:0] st6, st4, cur6, cur4;
  logic done6, done4, lv6, lv4;
  typedef struct {
    logic [23:0] td;
    logic [7:0]  pid;
    logic [2:0]  st, cur;
    logic        done, lv;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_pass = 0;
  int md[6];
  int mpid, mst, mcur;
  bit mlock, mdone, mlv;
  logic [4:0] mprev;
  always #5 clk = ~clk;
  time_set_control #(.NUM_DIGITS(6), .ID_W(8)) u6 (
    .clk(clk), .reset_n(reset_n), .btn_clear(btn[0]), .btn_set(btn[1]), .btn_load(btn[2]),
    .btn_start(btn[3]), .btn_stop(btn[4]), .mode_24h(mode_24h), .digit_sw(digit_sw), .id_sw(id_sw),
    .time_digits(td6), .patient_id(pid6), .state(st6), .set_cursor(cur6), .set_done(done6),
    .load_valid(lv6));
  time_set_control #(.NUM_DIGITS(4), .ID_W(8)) u4 (
    .clk(clk), .reset_n(reset_n), .btn_clear(btn[0]), .btn_set(btn[1]), .btn_load(btn[2]),
    .btn_start(btn[3]), .btn_stop(btn[4]), .mode_24h(mode_24h), .digit_sw(digit_sw), .id_sw(id_sw),
    .time_digits(td4), .patient_id(pid4), .state(st4), .set_cursor(cur4), .set_done(done4),
    .load_valid(lv4));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic int limit(int p, int t, bit m24);
    case (p)
      0: return m24 ? 2 : 1;
      1: if (m24) return (t == 2) ? 3 : 9; else return (t == 1) ? 2 : 9;
      2, 4: return 5;
      default: return 9;
    endcase
  endfunction
  task automatic model_reset();
    foreach (md[i]) md[i] = 0;
    mpid = 0; mst = 4; mcur = 0; mlock = 0; mdone = 0; mlv = 0; mprev = '0;
  endtask
  task automatic model_step(input logic [4:0] b);
    logic [4:0] e;
    int v, hl;
    e = b & ~mprev;
    mprev = b;
    mdone = 0;
    mlv = 0;
    if (e[0]) begin
      foreach (md[i]) md[i] = 0;
      mcur = 0; mlock = 0; mst = 0;
    end else if (e[1]) begin
      if (!mlock) begin
        v = int'(digit_sw);
        if (v > limit(mcur, md[0], mode_24h)) v = limit(mcur, md[0], mode_24h);
        md[mcur] = v;
        if (mcur == 0) begin
          hl = limit(1, v, mode_24h);
          if (md[1] > hl) md[1] = hl;
        end
        mst = 1;
        if (mcur == 5) begin mcur = 0; mdone = 1; end
        else mcur++;
      end
    end else if (e[2]) begin
      if (!mlock) begin mpid = int'(id_sw); mlv = 1; mst = 2; end
    end else if (e[3]) begin
      if (!mlock) begin mlock = 1; mst = 3; end
    end else if (e[4]) begin
      if (mst == 3) begin mlock = 0; mst = 5; end
    end
  endtask
  task automatic cyc(input logic [4:0] b);
    exp_t e;
    @(negedge clk);
    btn = b;
    model_step(b);
    e.td = {md[0][3:0], md[1][3:0], md[2][3:0], md[3][3:0], md[4][3:0], md[5][3:0]};
    e.pid = mpid[7:0];
    e.st = mst[2:0];
    e.cur = mcur[2:0];
    e.done = mdone;
    e.lv = mlv;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("time_digits", 32'(td6), 32'(e.td));
    chk("patient_id", 32'(pid6), 32'(e.pid));
    chk("state", 32'(st6), 32'(e.st));
    chk("set_cursor", 32'(cur6), 32'(e.cur));
    chk("set_done", 32'(done6), 32'(e.done));
    chk("load_valid", 32'(lv6), 32'(e.lv));
  endtask
  task automatic press(input logic [4:0] b);
    cyc(b);
    cyc('0);
  endtask
  task automatic set_digit(input logic [3:0] d);
    digit_sw = d;
    press(SETB);
  endtask
  initial begin
    int lvc;
    model_reset();
    #12;
    chk("rst_time", 32'(td6), 32'h0);
    chk("rst_pid", 32'(pid6), 32'h0);
    chk("rst_state", 32'(st6), 32'd4);
    chk("rst_cursor", 32'(cur6), 32'd0);
    chk("rst_pulses", 32'({done6, lv6}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    mode_24h = 1'b0;
    for (int i = 0; i < 6; i++) set_digit(4'hF);
    chk("12h_all_F", 32'(td6), 32'h125959);
    chk("12h_cursor_wrap", 32'(cur6), 32'd0);
    press(CLR);
    mode_24h = 1'b1;
    set_digit(4'd2);
    set_digit(4'd7);
    set_digit(4'd3);
    digit_sw = 4'd4;
    cyc(SETB);
    chk("24h_nd4_time", 32'(td4), 32'h2334);
    chk("24h_nd4_done", 32'(done4), 32'd1);
    cyc('0);
    chk("24h_nd6_time", 32'(td6), 32'h233400);
    press(CLR);
    mode_24h = 1'b0;
    set_digit(4'd0);
    set_digit(4'd9);
    for (int i = 0; i < 4; i++) set_digit(4'd0);
    set_digit(4'd1);
    chk("hour_reclamp", 32'(td6[23:16]), 32'h12);
    press(STA);
    set_digit(4'd5);
    id_sw = 8'h33;
    press(LD);
    chk("locked_state", 32'(st6), 32'd3);
    chk("locked_time", 32'(td6), 32'h120000);
    press(STP);
    chk("stopped_state", 32'(st6), 32'd5);
    set_digit(4'd1);
    chk("resume_edit", 32'(td6[23:16]), 32'h11);
    id_sw = 8'hA5;
    cyc(LD);
    chk("load_id", 32'(pid6), 32'hA5);
    cyc('0);
    lvc = 0;
    id_sw = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      cyc(LD);
      lvc += int'(lv6);
    end
    cyc('0);
    chk("held_one_event", 32'(lvc), 32'd1);
    chk("held_load_id", 32'(pid6), 32'h5A);
    press(CLR | SETB);
    chk("clear_wins", 32'(st6), 32'd0);
    set_digit(4'd1);
    press(STA);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_time", 32'(td6), 32'h0);
    chk("async_rst_state", 32'(st6), 32'd4);
    chk("async_rst_cursor", 32'(cur6), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    set_digit(4'd1);
    chk("post_rst_unlocked", 32'(st6), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
